// File: rtl/adder_share_ctrl.sv
// rtl/adder_share_ctrl.sv - time-shares one 16-bit adder among NREQ requesters
// Wide adds take two chained passes (LO then HI); results return on one tagged response channel.
`timescale 1ns/1ps
module adder_share_ctrl #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_wide,
  input  logic [NREQ*32-1:0]   req_x,
  input  logic [NREQ*32-1:0]   req_y,
  input  logic [NREQ-1:0]      req_cin,
  output logic [15:0]          add_x,
  output logic [15:0]          add_y,
  output logic                 add_cin,
  input  logic [15:0]          add_s,
  input  logic                 add_cout,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_sum,
  output logic                 rsp_cout
);

  typedef enum logic [1:0] {IDLE, LO, HI, RSP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [31:0]     x_q, x_d;
  logic [31:0]     y_q, y_d;
  logic [31:0]     sum_q, sum_d;
  logic            cin_q, cin_d;
  logic            wide_q, wide_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            rsp_valid_q, rsp_valid_d;

  logic [IDW-1:0]  grant;
  logic [IDW-1:0]  cand;
  logic            found;
  logic            accept;

  // Circular search starting at the round-robin pointer.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  // Gated by rst_n so every output reads zero while reset is held.
  assign req_ready = (rst_n && state_q == IDLE && found) ? (NREQ'(1) << grant) : '0;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    x_d         = x_q;
    y_d         = y_q;
    cin_d       = cin_q;
    wide_d      = wide_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    rsp_valid_d = rsp_valid_q;
    add_x       = '0;
    add_y       = '0;
    add_cin     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          x_d     = 32'(req_x >> {grant, 5'd0});
          y_d     = 32'(req_y >> {grant, 5'd0});
          cin_d   = |(req_cin & req_ready);
          wide_d  = |(req_wide & req_ready);
          id_d    = grant;
          ptr_d   = IDW'((int'(grant) + 1) % NREQ);
          state_d = LO;
        end
      end
      LO: begin
        add_x        = x_q[15:0];
        add_y        = y_q[15:0];
        add_cin      = cin_q;
        sum_d[15:0]  = add_s;
        carry_d      = add_cout;
        if (wide_q) begin
          state_d = HI;
        end else begin
          sum_d[31:16] = 16'h0;
          cout_d       = add_cout;
          rsp_valid_d  = 1'b1;
          state_d      = RSP;
        end
      end
      HI: begin
        add_x        = x_q[31:16];
        add_y        = y_q[31:16];
        add_cin      = carry_q;
        sum_d[31:16] = add_s;
        cout_d       = add_cout;
        rsp_valid_d  = 1'b1;
        state_d      = RSP;
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      cin_q       <= 1'b0;
      wide_q      <= 1'b0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cin_q       <= cin_d;
      wide_q      <= wide_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;

endmodule

// File: doc/adder_share_ctrl.md
Name: adder_share_ctrl

Overview:
Sequencing controller that time-shares one 16-bit combinational Adder (ports X, Y, cin, S, cout) among NREQ requesters. Each requester issues an add over a valid/ready handshake. Requests are either narrow (16-bit) or wide (32-bit). Wide adds run as two chained passes through the shared Adder, and results return on a single valid/ready response channel tagged with the requester id. The controller sits between requester blocks and the one Adder instance, which it drives and whose result it captures.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, $clog2(NREQ), width of requester id

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; one-hot or zero
req_wide  in  NREQ  1 = 32-bit add, 0 = 16-bit add
req_x  in  NREQ*32  operand X, requester i at [32*i+:32]; narrow uses [15:0]
req_y  in  NREQ*32  operand Y, same packing
req_cin  in  NREQ  carry-in per requester
add_x  out  16  to Adder X
add_y  out  16  to Adder Y
add_cin  out  1  to Adder cin
add_s  in  16  from Adder S
add_cout  in  1  from Adder cout
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_id  out  IDW  index of granted requester
rsp_sum  out  32  result; [31:16]=0 for narrow
rsp_cout  out  1  final carry-out

Behaviour:
- Clock and reset: one clock (clk); asynchronous active-low reset (rst_n); all flops reset asynchronously.
- Reset values:
  - state=IDLE.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0.
  - Round-robin pointer=0.
  - Operand and carry registers=0.
- Adder drive outside LO/HI: add_x, add_y, add_cin driven 0.
- FSM states: IDLE, LO, HI, RSP.
- IDLE:
  - Grant = first i with req_valid[i]=1, searching circularly from the pointer.
  - req_ready[grant]=1 combinationally in this cycle only; all other req_ready=0.
  - On acceptance (valid&ready):
    - latch x, y, cin, wide and id;
    - pointer <= (grant+1) mod NREQ;
    - next state LO.
  - No valid: stay IDLE, req_ready=0.
- LO:
  - Drive add_x=x[15:0], add_y=y[15:0], add_cin=cin.
  - Register sum[15:0]<=add_s and carry<=add_cout.
  - wide=1 → HI; wide=0 → RSP with sum[31:16]<=0 and rsp_cout<=add_cout.
- HI:
  - Drive add_x=x[31:16], add_y=y[31:16], add_cin=registered carry from LO.
  - Register sum[31:16]<=add_s and rsp_cout<=add_cout.
  - Next state RSP.
- RSP:
  - rsp_valid=1; rsp_id, rsp_sum, rsp_cout stable until rsp_ready=1.
  - On handshake: rsp_valid<=0, next state IDLE.
  - No grants while in RSP.
- Latency, acceptance to rsp_valid: narrow 2 cycles, wide 3 cycles.
- Minimum request spacing: 3 cycles narrow, 4 cycles wide.
- Arithmetic: modulo 2^16 (narrow) or 2^32 (wide).
  - rsp_cout = carry out of bit 15 (narrow) or bit 31 (wide).
  - Intermediate carry from LO is never reported for wide adds.
- Requester rules:
  - Requester operands may change after acceptance with no effect.
  - A requester dropping valid before acceptance is legal and loses no state.
- Reset asserted mid-operation (any state): return to IDLE immediately.
  - In-flight result is discarded; no rsp_valid is produced.
  - Pointer returns to 0.
- The controller is combinationally transparent to the Adder: no extra register stage on add_s or add_cout.

Test Plan:
- Narrow overflow: requester 1 sends X=0xFFFD, Y=0x0004, cin=1, wide=0 → rsp_id=1, rsp_sum=0x00000002, rsp_cout=1, rsp_valid 2 cycles after acceptance.
- Wide carry chain: X=0x0000FFFF, Y=0x00000001, cin=0, wide=1 → HI pass sees add_cin=1; rsp_sum=0x00010000, rsp_cout=0, 3-cycle latency.
- Wide overflow: X=0xFFFFFFFF, Y=0x00000000, cin=1 → rsp_sum=0x00000000, rsp_cout=1.
- Round-robin fairness: after reset all four req_valid held high with distinct operands → grants and rsp_id in order 0,1,2,3,0. After the last grant is 3, only requesters 0 and 2 valid → order 0 then 2.
- Backpressure: rsp_ready held low 5 cycles in RSP → rsp_valid, rsp_sum, rsp_id stable; req_ready stays 0; no new grant until the cycle after the handshake.
- Reset mid-wide: rst_n pulsed low during HI → all outputs 0 asynchronously, no response issued. A following request from requester 2 with other requesters idle gets granted normally.
- Random soak: 1000 random requests across requesters with random wide, cin and rsp_ready → scoreboard matches (x+y+cin) per width and per-id ordering.
